rf_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file among NUM_REQ writeback requesters, such as the ALU and the load unit.
- Each requester has a one-entry holding buffer. Full buffers are granted round-robin, and a registered write command drives the register file's RegWr/WriteReg/WriteData.
- A pending-write bitmap is exported so decode/read logic can stall on registers with writes in flight.

---
 rtl/rf_wb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared constants, payload type and id-width helper for the register-file writeback arbiter.
package rf_wb_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;

   // Requester index width; never below one bit so single-requester builds still elaborate
   function automatic int unsigned req_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned REQ_ID_W = req_id_w(2);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = req_id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [ID_W-1:0]    grant_idx_c,
   output logic               grant_any_c
);

   logic [ID_W-1:0] cand;

   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      grant_any_c = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(ptr_i) + k) % NUM_REQ);
         if (!grant_any_c && req_i[cand]) begin
            grant_any_c   = 1'b1;
            grant_c[cand] = 1'b1;
            grant_idx_c   = cand;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the single register-file write port.
// Optional RF_WB_ZERO_REG_EN: writes to register 0 are accepted and dropped.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DATA_W  = RF_DATA_W,
   parameter int unsigned ADDR_W  = RF_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [DATA_W-1:0]             wr_data,
   output logic [req_id_w(NUM_REQ)-1:0]  grant_id,
   output logic [(2**ADDR_W)-1:0]        pend_vec
);

   localparam int unsigned ID_W    = req_id_w(NUM_REQ);
   localparam int unsigned NUM_REG = 2**ADDR_W;

   // Holding buffers
   logic [NUM_REQ-1:0] full_q, full_d;
   logic [ADDR_W-1:0]  addr_q [NUM_REQ];
   logic [ADDR_W-1:0]  addr_d [NUM_REQ];
   logic [DATA_W-1:0]  data_q [NUM_REQ];
   logic [DATA_W-1:0]  data_d [NUM_REQ];

   // Output stage and arbitration state
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REG-1:0] pend_q, pend_d;

   logic [ADDR_W-1:0]  in_addr [NUM_REQ];
   logic [DATA_W-1:0]  in_data [NUM_REQ];
   logic [NUM_REQ-1:0] grant_c;
   logic [ID_W-1:0]    grant_idx_c;
   logic               grant_any_c;
   logic [NUM_REQ-1:0] req_ready_c;
   logic [NUM_REQ-1:0] zero_c;
   logic               blocked;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req_i       (full_q),
      .ptr_i       (ptr_q),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c),
      .grant_any_c (grant_any_c)
   );

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         in_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
         in_data[i] = req_data[i*DATA_W +: DATA_W];
      end
   end

   // A buffer leaving this cycle no longer blocks: its write reaches the port first
   always_comb begin
      req_ready_c = '0;
      zero_c      = '0;
      blocked     = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         blocked = 1'b0;
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (j != i) begin
               if (full_q[j] && !grant_c[j] && (addr_q[j] == in_addr[i]))
                  blocked = 1'b1;
               if ((j < i) && req_valid[j] && (in_addr[j] == in_addr[i]))
                  blocked = 1'b1;
            end
         end
`ifdef RF_WB_ZERO_REG_EN
         zero_c[i] = (in_addr[i] == '0);
`endif
         req_ready_c[i] = zero_c[i] | ((!full_q[i] | grant_c[i]) & !blocked);
      end
   end

   assign req_ready = req_ready_c;

   always_comb begin
      full_d     = full_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_en_d    = grant_any_c;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      pend_d     = '0;

      if (grant_any_c) begin
         wr_addr_d  = addr_q[grant_idx_c];
         wr_data_d  = data_q[grant_idx_c];
         grant_id_d = grant_idx_c;
         ptr_d      = ID_W'((32'(grant_idx_c) + 32'd1) % NUM_REQ);
      end

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i])
            full_d[i] = 1'b0;
         if (req_valid[i] && req_ready_c[i] && !zero_c[i]) begin
            full_d[i] = 1'b1;
            addr_d[i] = in_addr[i];
            data_d[i] = in_data[i];
         end
      end

      // Pending set mirrors exactly what will be buffered or staged after this edge
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (full_d[i])
            pend_d[addr_d[i]] = 1'b1;
      end
      if (wr_en_d)
         pend_d[wr_addr_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
         pend_q     <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         full_q     <= full_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
         pend_q     <= pend_d;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign grant_id = grant_id_q;
   assign pend_vec = pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then random traffic against a reference model.
module tb_rf_wb_arbiter;
   import rf_wb_pkg::*;

   localparam int unsigned N    = 2;
   localparam int unsigned AW   = RF_ADDR_W;
   localparam int unsigned DW   = RF_DATA_W;
   localparam int unsigned IW   = REQ_ID_W;
   localparam int unsigned NREG = 2**AW;
`ifdef RF_WB_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   typedef struct {
      wb_req_t req;
      int      id;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [IW-1:0]     grant_id;
   logic [NREG-1:0]   pend_vec;

   rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .grant_id  (grant_id),
      .pend_vec  (pend_vec)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   bit   init_done = 1'b0;
   exp_t exp_q[$];

   // Reference model: buffer contents, priority pointer and the address currently on the port
   bit          m_full [N];
   wb_req_t     m_buf  [N];
   int          m_ptr;
   bit          m_out_v;
   logic [AW-1:0] m_out_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int m_grant();
      for (int k = 0; k < int'(N); k++) begin
         int idx;
         idx = (m_ptr + k) % int'(N);
         if (m_full[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < int'(N); i++) begin
         m_full[i] = 1'b0;
         m_buf[i]  = '0;
      end
      m_ptr      = 0;
      m_out_v    = 1'b0;
      m_out_addr = '0;
   endtask

   task automatic step(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic r);
      logic [AW-1:0]   a [N];
      logic [DW-1:0]   d [N];
      bit              rdy [N];
      bit              zero [N];
      bit              hz;
      int              g;
      logic [NREG-1:0] pend;
      exp_t            e;
      a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
      @(negedge clk);
      rst       = r;
      req_valid = v;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      #1;
      g = m_grant();
      for (int i = 0; i < int'(N); i++) begin
         zero[i] = ZERO_EN && (a[i] == '0);
         hz = 1'b0;
         for (int j = 0; j < int'(N); j++) begin
            if (j != i && m_full[j] && j != g && m_buf[j].addr == a[i]) hz = 1'b1;
            if (j < i && v[j] && a[j] == a[i]) hz = 1'b1;
         end
         rdy[i] = zero[i] || ((!m_full[i] || g == i) && !hz);
      end
      pend = '0;
      for (int i = 0; i < int'(N); i++)
         if (m_full[i]) pend[m_buf[i].addr] = 1'b1;
      if (m_out_v) pend[m_out_addr] = 1'b1;
      if (init_done) begin
         for (int i = 0; i < int'(N); i++)
            chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(rdy[i]));
         chk("pend_vec", 64'(pend_vec), 64'(pend));
      end
      @(posedge clk);
      if (r) begin
         m_clear();
         exp_q.delete();
         init_done = 1'b1;
      end else if (init_done) begin
         if (g >= 0) begin
            e.req = m_buf[g];
            e.id  = g;
            exp_q.push_back(e);
            m_out_v    = 1'b1;
            m_out_addr = m_buf[g].addr;
            m_ptr      = (g + 1) % int'(N);
         end else begin
            m_out_v = 1'b0;
         end
         for (int i = 0; i < int'(N); i++) begin
            if (g == i) m_full[i] = 1'b0;
            if (v[i] && rdy[i] && !zero[i]) begin
               m_full[i]     = 1'b1;
               m_buf[i].addr = a[i];
               m_buf[i].data = d[i];
            end
         end
      end
   endtask

   // Monitor: every cycle the port must carry exactly the write the model granted last edge
   initial begin : monitor
      logic          r_edge;
      logic [AW-1:0] last_a;
      logic [DW-1:0] last_d;
      logic [IW-1:0] last_id;
      exp_t          e;
      last_a = '0; last_d = '0; last_id = '0;
      forever begin
         @(posedge clk);
         r_edge = rst;
         @(negedge clk);
         if (init_done) begin
            if (r_edge) begin
               last_a = '0; last_d = '0; last_id = '0;
            end
            chk("wr_en", 64'(wr_en), 64'(exp_q.size() > 0));
            if (wr_en === 1'b1 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(wr_addr), 64'(e.req.addr));
               chk("wr_data", 64'(wr_data), 64'(e.req.data));
               chk("grant_id", 64'(grant_id), 64'(e.id));
               last_a  = e.req.addr;
               last_d  = e.req.data;
               last_id = IW'(e.id);
            end else if (wr_en !== 1'b1) begin
               chk("wr_addr_hold", 64'(wr_addr), 64'(last_a));
               chk("wr_data_hold", 64'(wr_data), 64'(last_d));
               chk("grant_id_hold", 64'(grant_id), 64'(last_id));
               exp_q.delete();
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, '0, '0, '0, '0, 1'b0);
   endtask

   initial begin : driver
      m_clear();
      step('0, '0, '0, '0, '0, 1'b1);
      step('0, '0, '0, '0, '0, 1'b1);
      // Single write, minimum latency
      step(2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
      idle(4);
      // Two streams to distinct registers
      for (int k = 0; k < 4; k++) step(2'b11, 5'd4, 5'd5, $urandom, $urandom, 1'b0);
      idle(3);
      // Same-address collision: lower index first, higher follows on the grant cycle
      step(2'b11, 5'd7, 5'd7, 32'h1111_0000, 32'h2222_0000, 1'b0);
      step(2'b10, 5'd0, 5'd7, 32'h0, 32'h2222_0000, 1'b0);
      step(2'b10, 5'd0, 5'd7, 32'h0, 32'h2222_0001, 1'b0);
      idle(4);
      // Reset with both buffers full
      step(2'b11, 5'd10, 5'd11, 32'hAAAA, 32'hBBBB, 1'b0);
      step('0, '0, '0, '0, '0, 1'b1);
      idle(3);
      // Register zero
      step(2'b01, 5'd0, 5'd0, 32'h55, 32'h0, 1'b0);
      idle(3);
      // Back-pressure: requester 1 kept busy while requester 0 streams
      for (int k = 1; k <= 3; k++) step(2'b11, 5'(k), 5'd9, $urandom, $urandom, 1'b0);
      idle(4);
      // Random traffic over a small address window to provoke hazards
      for (int k = 0; k < 3000; k++) begin
         step(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom, $urandom, 1'($urandom_range(0, 199) == 0));
      end
      idle(12);
      @(negedge clk);
      #2;
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
